// File: rtl/layer_seq_pkg.sv
// ============================================================================
//  Module      : layer_seq_pkg
//  Description : Shared types and default constants for the layer sequencer.
//                Holds the sequencer state encoding, the default sizing
//                constants and a helper that sizes the layer index safely.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package layer_seq_pkg;

    localparam int DEF_NUM_PORTS  = 4;
    localparam int DEF_NUM_LAYERS = 3;
    localparam int DEF_TIMEOUT    = 255;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT      = 3'd2,
        ST_LAYER_END = 3'd3,
        ST_FINISH    = 3'd4
    } seq_state_t;

    // Width of an index over n items. A single-item range still needs one bit
    // so that the port never collapses to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : layer_seq_pkg

`default_nettype wire

// File: rtl/port_done_collector.sv
// ============================================================================
//  Module      : port_done_collector
//  Description : Accumulates per-port completion into a sticky vector and
//                reports when every port has completed. The all_done output
//                already includes this cycle's port_done so the sequencer can
//                react without waiting for the sticky register to update.
//  Ports       : clk       - rising-edge clock
//                rst_n     - asynchronous active-low reset
//                clear     - synchronous clear of the sticky vector
//                enable    - accumulate port_done this cycle
//                port_done - per-port completion (pulse or level)
//                all_done  - every port has completed (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module port_done_collector
    import layer_seq_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [NUM_PORTS-1:0] port_done,
    output logic                 all_done
);

    logic [NUM_PORTS-1:0] sticky;
    logic [NUM_PORTS-1:0] merged;

    // port_done only counts while collection is enabled.
    assign merged   = sticky | (enable ? port_done : '0);
    assign all_done = &merged;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= '0;
        end else if (clear) begin
            sticky <= '0;
        end else if (enable) begin
            sticky <= merged;
        end
    end

endmodule : port_done_collector

`default_nettype wire

// File: rtl/layer_sequencer.sv
// ============================================================================
//  Module      : layer_sequencer
//  Description : Runs a network pass of NUM_LAYERS layers. For each layer it
//                strobes port_start to all ports, waits until every port has
//                reported done, then advances. A WAIT phase lasting TIMEOUT
//                cycles without completion aborts the pass and raises a
//                sticky timeout_err.
//  Ports       : clk         - rising-edge clock
//                rst_n       - asynchronous active-low reset
//                start       - request a pass (honoured only when idle)
//                port_done   - per-port completion
//                port_start  - one-cycle launch strobe to every port
//                layer_idx   - current layer index
//                busy        - high whenever a pass is in progress
//                layer_done  - one-cycle pulse at end of each layer
//                net_done    - one-cycle pulse at end of the last layer
//                timeout_err - sticky abort flag, cleared by the next start
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [NUM_PORTS-1:0]             port_done,
    output logic [NUM_PORTS-1:0]             port_start,
    output logic [idx_width(NUM_LAYERS)-1:0] layer_idx,
    output logic                             busy,
    output logic                             layer_done,
    output logic                             net_done,
    output logic                             timeout_err
);

    localparam int IDX_W = idx_width(NUM_LAYERS);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_LAYER = IDX_W'(NUM_LAYERS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TIMEOUT);
    // The count equals the number of WAIT cycles already spent, so the cycle
    // holding TIMEOUT-1 is the last one allowed.
    localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT - 1);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             all_done;
    logic             collect_en;
    logic             collect_clr;
    logic             accept_start;
    logic             timeout_hit;
    logic             last_layer;

    assign last_layer = (layer_idx == LAST_LAYER);

    port_done_collector #(
        .NUM_PORTS (NUM_PORTS)
    ) u_collector (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (collect_clr),
        .enable    (collect_en),
        .port_done (port_done),
        .all_done  (all_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        port_start   = '0;
        busy         = (state != ST_IDLE);
        layer_done   = 1'b0;
        net_done     = 1'b0;
        collect_en   = (state == ST_LAUNCH) || (state == ST_WAIT);
        collect_clr  = 1'b0;
        accept_start = 1'b0;
        timeout_hit  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    collect_clr  = 1'b1;
                    state_next   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                port_start = '1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion is tested first so it wins over a same-cycle
                // timeout.
                if (all_done) begin
                    state_next = ST_LAYER_END;
                end else if (wait_cnt >= CNT_LIMIT) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_LAYER_END: begin
                layer_done  = 1'b1;
                collect_clr = 1'b1;
                state_next  = last_layer ? ST_FINISH : ST_LAUNCH;
            end
            ST_FINISH: begin
                net_done   = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // WAIT-cycle counter: restarts on every launch and saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == ST_LAUNCH) begin
            wait_cnt <= '0;
        end else if ((state == ST_WAIT) && (wait_cnt != CNT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Layer index is held after a pass and only cleared by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_idx <= '0;
        end else if (accept_start) begin
            layer_idx <= '0;
        end else if ((state == ST_LAYER_END) && !last_layer) begin
            layer_idx <= layer_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (accept_start) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end
    end

endmodule : layer_sequencer

`default_nettype wire

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of neuron ports sequenced per layer.
REQ-002 SHALL have parameter NUM_LAYERS, default 3: layers run per network pass.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum WAIT cycles before abort.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1: rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1: request a network pass; sampled only in IDLE.
REQ-008 SHALL have port port_done, input, NUM_PORTS: per-port completion; pulse or level.
REQ-009 SHALL have port port_start, output, NUM_PORTS: one-cycle launch strobe to every port.
REQ-010 SHALL have port layer_idx, output, clog2(NUM_LAYERS): index of the current layer.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-012 SHALL have port layer_done, output, 1: one-cycle pulse when all ports finish a layer.
REQ-013 SHALL have port net_done, output, 1: one-cycle pulse when the last layer finishes.
REQ-014 SHALL have port timeout_err, output, 1: sticky abort flag.

Function
REQ-015 SHALL implement the FSM states IDLE, LAUNCH, WAIT, LAYER_END and FINISH, all registered.
REQ-016 SHALL, in IDLE with start=1: clear layer_idx, the sticky done vector and timeout_err, then go to LAUNCH.
REQ-017 SHALL, in LAUNCH: drive port_start to all ones for exactly one cycle, clear the WAIT counter and go to WAIT.
REQ-018 SHALL, from LAUNCH through WAIT: OR port_done into the sticky vector each cycle, so a done arriving in the LAUNCH cycle is kept.
REQ-019 SHALL, in WAIT: go to LAYER_END in the cycle after the sticky vector (with the current port_done ORed in) is all ones.
REQ-020 SHALL, in LAYER_END: pulse layer_done and clear the sticky vector; if layer_idx=NUM_LAYERS-1 go to FINISH, else increment layer_idx and go to LAUNCH.
REQ-021 SHALL, in FINISH: pulse net_done, go to IDLE and hold layer_idx until the next accepted start.
REQ-022 SHALL ignore start outside IDLE and ignore port_done in IDLE, LAYER_END and FINISH.
REQ-023 SHALL, in WAIT: count cycles; if the count reaches TIMEOUT before completion, set timeout_err, go to IDLE and emit no layer_done or net_done.
REQ-024 SHALL give completion priority when completion and timeout occur in the same cycle.
REQ-025 SHALL treat simultaneous done on all ports, or repeated done on one port, as normal.
REQ-026 SHALL saturate the WAIT counter, and layer_idx SHALL never exceed NUM_LAYERS-1.

Reset
REQ-027 SHALL, on rst_n low at any time, set the state to IDLE and set port_start, layer_idx, busy, layer_done, net_done, timeout_err, the sticky vector and the counter to 0.
REQ-028 SHALL, when rst_n is asserted mid-pass, abandon the pass with no net_done pulse.

Structure
REQ-029 SHALL place the state enum and the default NUM_PORTS, NUM_LAYERS and TIMEOUT constants in a shared package, layer_seq_pkg.
REQ-030 SHALL implement sticky accumulation and the all-done compare in the sub-module port_done_collector (inputs clk, rst_n, clear, enable, port_done; output all_done).

Verification
REQ-031 SHALL cover the nominal pass: start at cycle 0, all ports done 3 cycles after each port_start -> port_start=4'b1111 three times, layer_idx 0,1,2, three layer_done pulses, one net_done, busy low afterwards.
REQ-032 SHALL cover staggered done: port_done = 4'b0001, 4'b0100, 4'b1010 on separate cycles -> layer_done exactly once, one cycle after the last port.
REQ-033 SHALL cover early done: port_done=4'b1111 during the LAUNCH cycle -> sequence LAYER_END, then layer_done, with no hang.
REQ-034 SHALL cover timeout: port 3 never asserts done, TIMEOUT=8 -> timeout_err=1 after 8 WAIT cycles, state IDLE, no net_done; the next start clears timeout_err.
REQ-035 SHALL cover mid-pass reset: rst_n low during layer 1 WAIT -> all outputs 0 immediately, and a new start begins at layer_idx=0.
REQ-036 SHALL cover busy start: start asserted during WAIT -> ignored, layer_idx unchanged, exactly one net_done.
